// File: rtl/mux_tree_pkg.sv
// Shared sizing helpers, radix constant and the per-stage control record for
// the pipelined mux tree.
package mux_tree_pkg;

    localparam int MUX_RADIX = 4;
    // Covers the largest supported NUM_IN (256 channels).
    localparam int MAX_SEL_W = 8;

    // Control half of a stage register. The data words ride alongside as a
    // flat vector because their width is set per instance.
    typedef struct packed {
        logic [MAX_SEL_W-1:0] sel_rem;
        logic [MAX_SEL_W-1:0] sel_full;
        logic                 valid;
    } stage_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int levels(input int sel_w);
        return (sel_w + 1) / 2;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_mux4_stage.sv
// One registered radix-4 level: every group of four words collapses to one
// using the low select pair, and the remaining select bits shift down.
module mux4_stage
    import mux_tree_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int FAN_IN = 4,
    localparam int FAN_OUT = FAN_IN / MUX_RADIX
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [FAN_IN*DATA_W-1:0]  in_words,
    input  stage_t                    in_ctl,
    output logic [FAN_OUT*DATA_W-1:0] out_words,
    output stage_t                    out_ctl
);

    logic [1:0]                pair;
    logic [FAN_OUT*DATA_W-1:0] pick;

    assign pair = in_ctl.sel_rem[1:0];

    always_comb begin
        pick = '0;
        for (int g = 0; g < FAN_OUT; g++) begin
            pick[g*DATA_W +: DATA_W] = in_words[(g*MUX_RADIX + int'(pair))*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_words <= '0;
            out_ctl   <= '0;
        end else if (en) begin
            out_words        <= pick;
            out_ctl.sel_rem  <= in_ctl.sel_rem >> 2;
            out_ctl.sel_full <= in_ctl.sel_full;
            out_ctl.valid    <= in_ctl.valid;
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN:1 selector built from radix-4 register stages.
// Define MUX_SCAN_EN to compile in the auto-scan channel stepper.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int NUM_IN = 16,
    parameter int DATA_W = 1,
    parameter int DWELL  = 1,
    localparam int SEL_W  = clog2(NUM_IN),
    localparam int LEVELS = levels(SEL_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    input  logic                     scan_mode,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid
);

    localparam int LEAVES    = 1 << (2 * LEVELS);
    localparam int LEAF_BITS = LEAVES * DATA_W;

    logic [SEL_W-1:0]     eff_sel;
    logic [LEAF_BITS-1:0] leaf_words;
    stage_t               head_ctl;
    logic [MAX_SEL_W-1:0] sel_rem_unused;

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] scan_ch;
    logic [15:0]      dwell_cnt;

    // Counters step only on beats accepted while scanning; a wrap uses the
    // pre-increment channel for the beat that triggers it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ch   <= '0;
            dwell_cnt <= '0;
        end else if (en && in_valid && scan_mode) begin
            if (dwell_cnt == 16'(DWELL - 1)) begin
                dwell_cnt <= '0;
                scan_ch   <= (scan_ch == SEL_W'(NUM_IN - 1)) ? '0 : scan_ch + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 16'd1;
            end
        end
    end

    assign eff_sel = scan_mode ? scan_ch : in_sel;
`else
    logic scan_mode_unused;
    localparam int DWELL_UNUSED = DWELL;

    assign scan_mode_unused = scan_mode;
    assign eff_sel          = in_sel;
`endif

    // Leaves beyond NUM_IN read as zero so out-of-range selects return 0.
    assign leaf_words = LEAF_BITS'(in_data);

    always_comb begin
        head_ctl          = '0;
        head_ctl.sel_rem  = MAX_SEL_W'(eff_sel);
        head_ctl.sel_full = MAX_SEL_W'(eff_sel);
        head_ctl.valid    = in_valid;
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int FAN_IN = LEAVES >> (2 * k);

        logic [FAN_IN*DATA_W-1:0]           words;
        stage_t                             ctl;
        logic [FAN_IN/MUX_RADIX*DATA_W-1:0] q_words;
        stage_t                             q_ctl;

        if (k == 0) begin : g_head
            assign words = leaf_words;
            assign ctl   = head_ctl;
        end else begin : g_link
            assign words = g_stage[k-1].q_words;
            assign ctl   = g_stage[k-1].q_ctl;
        end

        mux4_stage #(
            .DATA_W(DATA_W),
            .FAN_IN(FAN_IN)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_words (words),
            .in_ctl   (ctl),
            .out_words(q_words),
            .out_ctl  (q_ctl)
        );
    end

    assign out_data       = g_stage[LEVELS-1].q_words;
    assign out_sel        = SEL_W'(g_stage[LEVELS-1].q_ctl.sel_full);
    assign out_valid      = g_stage[LEVELS-1].q_ctl.valid;
    assign sel_rem_unused = g_stage[LEVELS-1].q_ctl.sel_rem;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: NUM_IN=16, NUM_IN=10 (padded tree) and
// NUM_IN=4 with DWELL=2 (scan path when MUX_SCAN_EN is defined).
module tb_mux_tree_pipe;

    localparam int L16 = 2;
    localparam int L10 = 2;
    localparam int L4  = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] d16;
    logic [3:0]   sel16, o16_s;
    logic         v16, o16_v;
    logic [7:0]   o16_d;

    logic [79:0]  d10;
    logic [3:0]   sel10, o10_s;
    logic         v10, o10_v;
    logic [7:0]   o10_d;

    logic [31:0]  d4;
    logic [1:0]   sel4, o4_s;
    logic         v4, o4_v, scan4;
    logic [7:0]   o4_d;

    logic scan_off = 1'b0;

    mux_tree_pipe #(.NUM_IN(16), .DATA_W(8), .DWELL(1)) u_dut16 (
        .clk(clk), .rst(rst), .en(en), .in_data(d16), .in_sel(sel16), .in_valid(v16),
        .scan_mode(scan_off), .out_data(o16_d), .out_sel(o16_s), .out_valid(o16_v)
    );

    mux_tree_pipe #(.NUM_IN(10), .DATA_W(8), .DWELL(1)) u_dut10 (
        .clk(clk), .rst(rst), .en(en), .in_data(d10), .in_sel(sel10), .in_valid(v10),
        .scan_mode(scan_off), .out_data(o10_d), .out_sel(o10_s), .out_valid(o10_v)
    );

    mux_tree_pipe #(.NUM_IN(4), .DATA_W(8), .DWELL(2)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .in_data(d4), .in_sel(sel4), .in_valid(v4),
        .scan_mode(scan4), .out_data(o4_d), .out_sel(o4_s), .out_valid(o4_v)
    );

    // Scoreboard entries: {due edge count[15:0], sel[7:0], data[7:0]}.
    logic [31:0] exp16_q[$], exp10_q[$], exp4_q[$];
    logic [31:0] e16, e10, e4;
    logic [15:0] le16, le10, le4;
    logic        ev16, ev10, ev4;
    int          ecnt = 0;
    logic        adv = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          model_ch = 0;
    int          model_dwell = 0;
    logic [1:0]  s4;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Expected responses are queued at the edge that accepts each beat.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp16_q.delete();
            exp10_q.delete();
            exp4_q.delete();
            adv         = 1'b0;
            model_ch    = 0;
            model_dwell = 0;
        end else begin
            adv = en;
            if (en) begin
                ecnt++;
                if (v16)
                    exp16_q.push_back({16'(ecnt + L16 - 1), 8'(sel16), 8'(8'hA0 + 8'(sel16))});
                if (v10)
                    exp10_q.push_back({16'(ecnt + L10 - 1), 8'(sel10),
                                       (sel10 < 4'd10) ? 8'(8'hA0 + 8'(sel10)) : 8'h00});
                if (v4) begin
`ifdef MUX_SCAN_EN
                    if (scan4) begin
                        s4 = 2'(model_ch);
                        if (model_dwell == 1) begin
                            model_dwell = 0;
                            model_ch    = (model_ch == 3) ? 0 : model_ch + 1;
                        end else begin
                            model_dwell++;
                        end
                    end else begin
                        s4 = sel4;
                    end
`else
                    s4 = sel4;
`endif
                    exp4_q.push_back({16'(ecnt + L4 - 1), 8'(s4), 8'(8'hA0 + 8'(s4))});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            ev16 = 1'b0;
        end else if (adv) begin
            if (exp16_q.size() > 0 && exp16_q[0][31:16] == 16'(ecnt)) begin
                e16 = exp16_q.pop_front();
                check("dut16 beat valid", 16'(o16_v), 16'd1);
                check("dut16 data", 16'(o16_d), 16'(e16[7:0]));
                check("dut16 sel", 16'(o16_s), 16'(e16[15:8]));
                ev16 = 1'b1;
                le16 = e16[15:0];
            end else begin
                check("dut16 idle valid", 16'(o16_v), 16'd0);
                ev16 = 1'b0;
            end
        end else begin
            check("dut16 hold valid", 16'(o16_v), 16'(ev16));
            if (ev16) begin
                check("dut16 hold data", 16'(o16_d), 16'(le16[7:0]));
                check("dut16 hold sel", 16'(o16_s), 16'(le16[15:8]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            ev10 = 1'b0;
        end else if (adv) begin
            if (exp10_q.size() > 0 && exp10_q[0][31:16] == 16'(ecnt)) begin
                e10 = exp10_q.pop_front();
                check("dut10 beat valid", 16'(o10_v), 16'd1);
                check("dut10 data", 16'(o10_d), 16'(e10[7:0]));
                check("dut10 sel", 16'(o10_s), 16'(e10[15:8]));
                ev10 = 1'b1;
                le10 = e10[15:0];
            end else begin
                check("dut10 idle valid", 16'(o10_v), 16'd0);
                ev10 = 1'b0;
            end
        end else begin
            check("dut10 hold valid", 16'(o10_v), 16'(ev10));
            if (ev10) check("dut10 hold data", 16'(o10_d), 16'(le10[7:0]));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            ev4 = 1'b0;
        end else if (adv) begin
            if (exp4_q.size() > 0 && exp4_q[0][31:16] == 16'(ecnt)) begin
                e4 = exp4_q.pop_front();
                check("dut4 beat valid", 16'(o4_v), 16'd1);
                check("dut4 data", 16'(o4_d), 16'(e4[7:0]));
                check("dut4 sel", 16'(o4_s), 16'(e4[15:8]));
                ev4 = 1'b1;
                le4 = e4[15:0];
            end else begin
                check("dut4 idle valid", 16'(o4_v), 16'd0);
                ev4 = 1'b0;
            end
        end else begin
            check("dut4 hold valid", 16'(o4_v), 16'(ev4));
            if (ev4) check("dut4 hold sel", 16'(o4_s), 16'(le4[15:8]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat16(input int s);
        sel16 = 4'(s);
        v16   = 1'b1;
        step();
        v16   = 1'b0;
    endtask

    task automatic beat10(input int s);
        sel10 = 4'(s);
        v10   = 1'b1;
        step();
        v10   = 1'b0;
    endtask

    task automatic beat4(input int s);
        sel4 = 2'(s);
        v4   = 1'b1;
        step();
        v4   = 1'b0;
    endtask

    int seq_b2b[4] = '{0, 15, 7, 3};
    int seq_pad[4] = '{12, 9, 15, 0};

    initial begin
        for (int i = 0; i < 16; i++) d16[i*8 +: 8] = 8'(8'hA0 + i);
        for (int i = 0; i < 10; i++) d10[i*8 +: 8] = 8'(8'hA0 + i);
        for (int i = 0; i < 4; i++)  d4[i*8 +: 8]  = 8'(8'hA0 + i);
        sel16 = '0; sel10 = '0; sel4 = '0;
        v16 = 1'b0; v10 = 1'b0; v4 = 1'b0; scan4 = 1'b0;

        #1 rst = 1'b1;
        #1;
        check("reset out_valid16", 16'(o16_v), 16'd0);
        check("reset out_data16", 16'(o16_d), 16'd0);
        check("reset out_sel16", 16'(o16_s), 16'd0);
        check("reset out_valid10", 16'(o10_v), 16'd0);
        check("reset out_data10", 16'(o10_d), 16'd0);
        check("reset out_valid4", 16'(o4_v), 16'd0);
        check("reset out_sel4", 16'(o4_s), 16'd0);
        step();
        step();
        rst = 1'b0;

        // Single beat, channel 5.
        beat16(5);
        repeat (4) step();

        // Back-to-back beats with select changes every cycle.
        foreach (seq_b2b[i]) beat16(seq_b2b[i]);
        repeat (4) step();

        // Padded tree: selects 12 and 15 land on zero leaves.
        foreach (seq_pad[i]) beat10(seq_pad[i]);
        repeat (4) step();

        // Stall for 3 cycles with beats in flight and one pending.
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) begin
                en    = 1'b0;
                sel16 = 4'(i);
                v16   = 1'b1;
                repeat (3) step();
                en    = 1'b1;
            end
            beat16(i);
        end
        repeat (4) step();

        // Scan mode stream (manual selects are used when the scan path is absent).
        scan4 = 1'b1;
        for (int i = 0; i < 10; i++) beat4(i * 3);
        repeat (3) step();

        // Reset pulse with beats in flight.
        sel16 = 4'd9; sel4 = 2'd1; v16 = 1'b1; v4 = 1'b1;
        step();
        sel16 = 4'd10; sel4 = 2'd2;
        step();
        v16 = 1'b0; v4 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid reset out_valid16", 16'(o16_v), 16'd0);
        check("mid reset out_valid4", 16'(o4_v), 16'd0);
        step();
        rst = 1'b0;
        beat4(3);
        beat4(2);
        beat16(14);
        repeat (5) step();

        check("dut16 queue drained", 16'(exp16_q.size()), 16'd0);
        check("dut10 queue drained", 16'(exp10_q.size()), 16'd0);
        check("dut4 queue drained", 16'(exp4_q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
